idex_ctrl_pipe: RTL and testbench

IDEX_CTRL_PIPE -- requirements
Module: idex_ctrl_pipe

---
 rtl/idex_ctrl_pipe.sv | 104 ++++++++++
 tb/tb_idex_ctrl_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_ctrl_pipe.sv
// ID/EX control pipeline register with stall, bubble and flush handling.
// Counts inserted zero-loads in a saturating statistics counter.
module idex_ctrl_pipe #(
  parameter int EX_W  = 5,
  parameter int M_W   = 3,
  parameter int WB_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [EX_W-1:0]  id_EX,
  input  logic [M_W-1:0]   id_M,
  input  logic [WB_W-1:0]  id_WB,
  input  logic             idex_stall,
  input  logic             idex_bubble,
  input  logic             idex_flush,
  input  logic             cnt_clr,
  output logic             idex_valid,
  output logic [EX_W-1:0]  idex_EX,
  output logic [M_W-1:0]   idex_M,
  output logic [WB_W-1:0]  idex_WB,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic             bubble_sat
);

  logic             valid_q, valid_d;
  logic [EX_W-1:0]  ex_q, ex_d;
  logic [M_W-1:0]   m_q, m_d;
  logic [WB_W-1:0]  wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             zero_load;

  always_comb begin
    valid_d   = valid_q;
    ex_d      = ex_q;
    m_d       = m_q;
    wb_d      = wb_q;
    zero_load = 1'b0;
    priority case (1'b1)
      idex_flush: begin
        valid_d   = 1'b0;
        ex_d      = '0;
        m_d       = '0;
        wb_d      = '0;
        zero_load = 1'b1;
      end
      idex_stall: begin
        valid_d = valid_q;
      end
      idex_bubble: begin
        valid_d   = 1'b0;
        ex_d      = '0;
        m_d       = '0;
        wb_d      = '0;
        zero_load = 1'b1;
      end
      default: begin
        valid_d = id_valid;
        ex_d    = id_EX;
        m_d     = id_M;
        wb_d    = id_WB;
      end
    endcase
  end

  // Clear beats a same-edge zero-load; counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (zero_load && !sat_q) begin
      cnt_d = cnt_q + 1'b1;
    end
    sat_d = (cnt_d == {CNT_W{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
      m_q     <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ex_q    <= ex_d;
      m_q     <= m_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign idex_valid = valid_q;
  assign idex_EX    = ex_q;
  assign idex_M     = m_q;
  assign idex_WB    = wb_q;
  assign bubble_cnt = cnt_q;
  assign bubble_sat = sat_q;

endmodule

// File: tb/tb_idex_ctrl_pipe.sv
// Directed bench for idex_ctrl_pipe: a CNT_W=4 instance for control tests
// and an 8/4/2-wide instance for the parameter check.
module tb_idex_ctrl_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_EX = '0;
  logic [2:0] id_M = '0;
  logic [2:0] id_WB = '0;
  logic       stall = 1'b0;
  logic       bubble = 1'b0;
  logic       flush = 1'b0;
  logic       clr = 1'b0;

  logic       a_v;
  logic [4:0] a_ex;
  logic [2:0] a_m;
  logic [2:0] a_wb;
  logic [3:0] a_cnt;
  logic       a_sat;

  logic [7:0]  b_id_ex = '0;
  logic [3:0]  b_id_m = '0;
  logic [1:0]  b_id_wb = '0;
  logic        b_v;
  logic [7:0]  b_ex;
  logic [3:0]  b_m;
  logic [1:0]  b_wb;
  logic [15:0] b_cnt;
  logic        b_sat;

  int vectors = 0;
  int miscompares = 0;

  // {valid, EX, M, WB, cnt, sat}
  logic [16:0] a_obs;
  assign a_obs = {a_v, a_ex, a_m, a_wb, a_cnt, a_sat};
  logic [14:0] b_obs;
  assign b_obs = {b_v, b_ex, b_m, b_wb};

  idex_ctrl_pipe #(
    .EX_W(5), .M_W(3), .WB_W(3), .CNT_W(4)
  ) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_EX(id_EX), .id_M(id_M), .id_WB(id_WB),
    .idex_stall(stall), .idex_bubble(bubble),
    .idex_flush(flush), .cnt_clr(clr),
    .idex_valid(a_v), .idex_EX(a_ex), .idex_M(a_m),
    .idex_WB(a_wb), .bubble_cnt(a_cnt),
    .bubble_sat(a_sat)
  );

  idex_ctrl_pipe #(
    .EX_W(8), .M_W(4), .WB_W(2), .CNT_W(16)
  ) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_EX(b_id_ex), .id_M(b_id_m), .id_WB(b_id_wb),
    .idex_stall(stall), .idex_bubble(bubble),
    .idex_flush(flush), .cnt_clr(clr),
    .idex_valid(b_v), .idex_EX(b_ex), .idex_M(b_m),
    .idex_WB(b_wb), .bubble_cnt(b_cnt),
    .bubble_sat(b_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0;
    bubble = 1'b0;
    flush = 1'b0;
    clr = 1'b0;
  endtask

  task automatic load_15();
    id_valid = 1'b1;
    id_EX = 5'h15;
    id_M = 3'h5;
    id_WB = 3'h3;
  endtask

  task automatic test_reset();
    logic [16:0] exp;
    idle();
    rst = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    tick();
    exp = '0;
    vectors++;
    if (a_obs !== exp) begin
      miscompares++;
      $display("FAIL reset_a got %h want %h", a_obs, exp);
    end
    vectors++;
    if ({b_obs, b_cnt, b_sat} !== '0) begin
      miscompares++;
      $display("FAIL reset_b got %h/%h/%b want 0",
               b_obs, b_cnt, b_sat);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_load();
    logic [16:0] exp;
    load_15();
    tick();
    exp = {1'b1, 5'h15, 3'h5, 3'h3, 4'h0, 1'b0};
    vectors++;
    if (a_obs !== exp) begin
      miscompares++;
      $display("FAIL load got %h want %h", a_obs, exp);
    end
  endtask

  task automatic test_stall();
    logic [16:0] exp;
    stall = 1'b1;
    id_EX = 5'h0A;
    id_valid = 1'b0;
    exp = {1'b1, 5'h15, 3'h5, 3'h3, 4'h0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (a_obs !== exp) begin
        miscompares++;
        $display("FAIL stall%0d got %h want %h", i, a_obs, exp);
      end
    end
    idle();
  endtask

  task automatic test_flush_stall();
    logic [16:0] exp;
    stall = 1'b1;
    flush = 1'b1;
    load_15();
    tick();
    exp = {1'b0, 5'h0, 3'h0, 3'h0, 4'h1, 1'b0};
    vectors++;
    if (a_obs !== exp) begin
      miscompares++;
      $display("FAIL flush_stall got %h want %h", a_obs, exp);
    end
    idle();
    tick();
    exp = {1'b1, 5'h15, 3'h5, 3'h3, 4'h1, 1'b0};
    vectors++;
    if (a_obs !== exp) begin
      miscompares++;
      $display("FAIL reload got %h want %h", a_obs, exp);
    end
    stall = 1'b1;
    bubble = 1'b1;
    id_EX = 5'h1F;
    tick();
    vectors++;
    if (a_obs !== exp) begin
      miscompares++;
      $display("FAIL stall_bubble got %h want %h", a_obs, exp);
    end
    idle();
  endtask

  task automatic test_invalid_passthru();
    logic [16:0] exp;
    id_valid = 1'b0;
    id_EX = 5'h1F;
    id_M = 3'h7;
    id_WB = 3'h1;
    tick();
    exp = {1'b0, 5'h1F, 3'h7, 3'h1, 4'h1, 1'b0};
    vectors++;
    if (a_obs !== exp) begin
      miscompares++;
      $display("FAIL passthru got %h want %h", a_obs, exp);
    end
  endtask

  task automatic test_clr_fields();
    logic [16:0] exp;
    clr = 1'b1;
    load_15();
    tick();
    exp = {1'b1, 5'h15, 3'h5, 3'h3, 4'h0, 1'b0};
    vectors++;
    if (a_obs !== exp) begin
      miscompares++;
      $display("FAIL clr_fields got %h want %h", a_obs, exp);
    end
    idle();
  endtask

  task automatic test_saturation();
    logic [4:0] exp;
    bubble = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      exp = {4'(i + 1), (i == 14)};
      vectors++;
      if ({a_cnt, a_sat} !== exp || a_v !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_step%0d got %h/%b v=%b want %h",
                 i, a_cnt, a_sat, a_v, exp);
      end
    end
    tick();
    vectors++;
    if ({a_cnt, a_sat} !== 5'b11111) begin
      miscompares++;
      $display("FAIL sat_hold got %h/%b want f/1", a_cnt, a_sat);
    end
    clr = 1'b1;
    tick();
    vectors++;
    if ({a_cnt, a_sat} !== 5'b00000) begin
      miscompares++;
      $display("FAIL sat_clr got %h/%b want 0/0", a_cnt, a_sat);
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    logic [16:0] exp;
    bubble = 1'b1;
    repeat (7) tick();
    idle();
    load_15();
    tick();
    exp = {1'b1, 5'h15, 3'h5, 3'h3, 4'h7, 1'b0};
    vectors++;
    if (a_obs !== exp) begin
      miscompares++;
      $display("FAIL pre_rst got %h want %h", a_obs, exp);
    end
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (a_obs !== '0) begin
      miscompares++;
      $display("FAIL rst_stall got %h want 0", a_obs);
    end
    rst = 1'b0;
    idle();
    id_EX = 5'h0C;
    id_M = 3'h2;
    id_WB = 3'h6;
    tick();
    exp = {1'b1, 5'h0C, 3'h2, 3'h6, 4'h0, 1'b0};
    vectors++;
    if (a_obs !== exp) begin
      miscompares++;
      $display("FAIL post_rst got %h want %h", a_obs, exp);
    end
  endtask

  task automatic test_params();
    logic [14:0] exp;
    id_valid = 1'b1;
    b_id_ex = 8'hFF;
    b_id_m = 4'hF;
    b_id_wb = 2'h3;
    tick();
    exp = {1'b1, 8'hFF, 4'hF, 2'h3};
    vectors++;
    if (b_obs !== exp) begin
      miscompares++;
      $display("FAIL wide_load got %h want %h", b_obs, exp);
    end
    flush = 1'b1;
    tick();
    vectors++;
    if (b_obs !== '0 || b_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL wide_flush got %h cnt %h want 0/1",
               b_obs, b_cnt);
    end
    idle();
  endtask

  initial begin
    tick();
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_invalid_passthru();
    test_clr_fields();
    test_saturation();
    test_reset_mid_stall();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
